// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: execute-stage sequencer for the branch condition unit.
// Define BR_STATS_EN to add saturating branch / mispredict counters.
module branch_resolve_ctrl #(
    parameter int XLEN    = 32,
    parameter int PC_STEP = 4
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef BR_STATS_EN
    output logic [31:0]     br_cnt,
    output logic [31:0]     mis_cnt,
`endif
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [3:0]      br_bf,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_off,
    input  logic            br_pred,
    input  logic            ops_rdy,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            kill,
    output logic [XLEN-1:0] bce_a,
    output logic [XLEN-1:0] bce_b,
    output logic [3:0]      bce_bf,
    input  logic            bce_res,
    output logic            stall,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_OPS = 2'd1,
        S_EVAL     = 2'd2,
        S_RESOLVE  = 2'd3
    } state_t;

    state_t            r_state;

    // latched branch descriptor
    logic [3:0]        r_bf;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_off;
    logic              r_pred;

    // operand / function registers feeding the BCEU
    logic [XLEN-1:0]   r_bce_a;
    logic [XLEN-1:0]   r_bce_b;
    logic [3:0]        r_bce_bf;

    // resolution results
    logic              r_mispred;
    logic [XLEN-1:0]   r_tgt;
    logic [XLEN-1:0]   r_pc_hold;

    logic              w_accept;
    logic              w_legal;
    logic              w_taken;
    logic [XLEN-1:0]   w_fall;
    logic [XLEN-1:0]   w_jump;
    logic              w_redirect;

    // only the compare encodings the BCEU really implements may be taken
    function automatic logic f_legal(input logic [3:0] bf);
        return (bf == 4'b0010) || (bf == 4'b0011) || bf[3];
    endfunction

    assign w_accept = (r_state == S_IDLE) & br_valid & ~kill;
    assign w_legal  = f_legal(r_bf);
    assign w_taken  = bce_res & w_legal;
    assign w_fall   = r_pc + XLEN'(PC_STEP);
    assign w_jump   = w_fall + r_off;

    // a kill arriving in the resolve cycle still suppresses the redirect
    assign w_redirect = r_mispred & ~kill;

    assign br_ready       = (r_state == S_IDLE);
    assign stall          = (r_state == S_WAIT_OPS);
    assign bce_a          = r_bce_a;
    assign bce_b          = r_bce_b;
    assign bce_bf         = r_bce_bf;
    assign redirect_valid = w_redirect;
    assign flush          = w_redirect;
    assign redirect_pc    = w_redirect ? r_tgt : r_pc_hold;

    // branch sequencing FSM with registered BCEU drive and redirect state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bf      <= 4'b0000;
            r_pc      <= '0;
            r_off     <= '0;
            r_pred    <= 1'b0;
            r_bce_a   <= '0;
            r_bce_b   <= '0;
            r_bce_bf  <= 4'b0000;
            r_mispred <= 1'b0;
            r_tgt     <= '0;
            r_pc_hold <= '0;
        end else begin
            r_mispred <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_bce_bf <= 4'b0000;
                    if (w_accept) begin
                        r_bf   <= br_bf;
                        r_pc   <= br_pc;
                        r_off  <= br_off;
                        r_pred <= br_pred;
                        if (ops_rdy) begin
                            r_bce_a  <= rs_val;
                            r_bce_b  <= rt_val;
                            r_bce_bf <= br_bf;
                            r_state  <= S_EVAL;
                        end else begin
                            r_state  <= S_WAIT_OPS;
                        end
                    end
                end
                S_WAIT_OPS: begin
                    if (kill) begin
                        r_state <= S_IDLE;
                    end else if (ops_rdy) begin
                        r_bce_a  <= rs_val;
                        r_bce_b  <= rt_val;
                        r_bce_bf <= r_bf;
                        r_state  <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    r_bce_bf <= 4'b0000;
                    if (kill) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_mispred <= (w_taken != r_pred);
                        r_tgt     <= w_taken ? w_jump : w_fall;
                        r_state   <= S_RESOLVE;
                    end
                end
                S_RESOLVE: begin
                    r_bce_bf <= 4'b0000;
                    if (w_redirect) begin
                        r_pc_hold <= r_tgt;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_bce_bf <= 4'b0000;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BR_STATS_EN
    logic [31:0] r_br_cnt;
    logic [31:0] r_mis_cnt;

    // saturating counts of resolved branches and of redirects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_cnt  <= '0;
            r_mis_cnt <= '0;
        end else if ((r_state == S_RESOLVE) && !kill) begin
            if (r_br_cnt != 32'hFFFF_FFFF) begin
                r_br_cnt <= r_br_cnt + 32'd1;
            end
            if (r_mispred && (r_mis_cnt != 32'hFFFF_FFFF)) begin
                r_mis_cnt <= r_mis_cnt + 32'd1;
            end
        end
    end

    assign br_cnt  = r_br_cnt;
    assign mis_cnt = r_mis_cnt;
`else
    // statistics counters not built
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed and random branches against a timeline model.
// Stats ports are connected and checked only when BR_STATS_EN is defined.
module tb_branch_resolve_ctrl;

    logic        clk;
    logic        rst_n;
    logic        br_valid;
    logic        br_ready;
    logic [3:0]  br_bf;
    logic [31:0] br_pc;
    logic [31:0] br_off;
    logic        br_pred;
    logic        ops_rdy;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        kill;
    logic [31:0] bce_a;
    logic [31:0] bce_b;
    logic [3:0]  bce_bf;
    logic        bce_res;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
`ifdef BR_STATS_EN
    logic [31:0] br_cnt;
    logic [31:0] mis_cnt;
`endif

    int          n_tot;
    int          n_pass;
    logic [31:0] m_last_rpc;
    int          m_br;
    int          m_mis;

    branch_resolve_ctrl #(.XLEN(32), .PC_STEP(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
`ifdef BR_STATS_EN
        .br_cnt         (br_cnt),
        .mis_cnt        (mis_cnt),
`endif
        .br_valid       (br_valid),
        .br_ready       (br_ready),
        .br_bf          (br_bf),
        .br_pc          (br_pc),
        .br_off         (br_off),
        .br_pred        (br_pred),
        .ops_rdy        (ops_rdy),
        .rs_val         (rs_val),
        .rt_val         (rt_val),
        .kill           (kill),
        .bce_a          (bce_a),
        .bce_b          (bce_b),
        .bce_bf         (bce_bf),
        .bce_res        (bce_res),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // combinational BCEU stand-in; unimplemented codes answer 1
    function automatic logic bceu(input logic [31:0] a,
                                  input logic [31:0] b,
                                  input logic [3:0]  bf);
        case (bf)
            4'b0000: return 1'b0;
            4'b0010: return a[31];
            4'b0011: return !a[31];
            4'b1000: return a == b;
            4'b1001: return a != b;
            4'b1010: return $signed(a) < $signed(b);
            4'b1011: return $signed(a) >= $signed(b);
            4'b1100: return a < b;
            4'b1101: return a >= b;
            4'b1110: return a[31] || (a == 32'd0);
            4'b1111: return !a[31] && (a != 32'd0);
            default: return 1'b1;
        endcase
    endfunction

    assign bce_res = bceu(bce_a, bce_b, bce_bf);

    function automatic logic legal(input logic [3:0] bf);
        return (bf == 4'b0010) || (bf == 4'b0011) || (bf >= 4'b1000);
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic garbage();
        br_valid = 1'($urandom_range(0, 1));
        br_bf    = 4'($urandom);
        br_pc    = $urandom;
        br_off   = $urandom;
        br_pred  = 1'($urandom_range(0, 1));
        ops_rdy  = 1'($urandom_range(0, 1));
        rs_val   = $urandom;
        rt_val   = $urandom;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // killc: -1 none, 0 kill in first wait cycle, 1 in EVAL, 2 in RESOLVE
    task automatic run_branch(input logic [3:0]  bf,
                              input logic [31:0] pc,
                              input logic [31:0] off,
                              input logic        pred,
                              input logic [31:0] rs,
                              input logic [31:0] rt,
                              input int          d,
                              input int          killc);
        logic        tk;
        logic        mis;
        logic        exp_rv;
        logic [31:0] tgt;
        tk  = legal(bf) && bceu(rs, rt, bf);
        mis = (tk != pred);
        tgt = tk ? (pc + 32'd4 + off) : (pc + 32'd4);

        br_valid = 1'b1;
        br_bf    = bf;
        br_pc    = pc;
        br_off   = off;
        br_pred  = pred;
        kill     = 1'b0;
        ops_rdy  = (d == 0);
        rs_val   = (d == 0) ? rs : $urandom;
        rt_val   = (d == 0) ? rt : $urandom;
        #2;
        chk("idle_ready", 32'(br_ready), 32'd1);
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_rv", 32'(redirect_valid), 32'd0);
        chk("idle_flush", 32'(flush), 32'd0);
        chk("idle_bf", 32'(bce_bf), 32'd0);
        next_cycle();

        for (int i = 1; i <= d; i++) begin
            garbage();
            ops_rdy = (i == d);
            if (i == d) begin
                rs_val = rs;
                rt_val = rt;
            end
            kill = (killc == 0) && (i == 1);
            #2;
            chk("wait_stall", 32'(stall), 32'd1);
            chk("wait_ready", 32'(br_ready), 32'd0);
            chk("wait_bf", 32'(bce_bf), 32'd0);
            next_cycle();
            if (kill) begin
                kill     = 1'b0;
                br_valid = 1'b0;
                return;
            end
        end

        garbage();
        kill = (killc == 1);
        #2;
        chk("eval_bf", 32'(bce_bf), 32'(bf));
        chk("eval_a", bce_a, rs);
        chk("eval_b", bce_b, rt);
        chk("eval_stall", 32'(stall), 32'd0);
        chk("eval_ready", 32'(br_ready), 32'd0);
        next_cycle();
        if (killc == 1) begin
            kill     = 1'b0;
            br_valid = 1'b0;
            return;
        end

        garbage();
        kill   = (killc == 2);
        exp_rv = mis && (killc != 2);
        #2;
        chk("res_rv", 32'(redirect_valid), 32'(exp_rv));
        chk("res_flush", 32'(flush), 32'(exp_rv));
        chk("res_pc", redirect_pc, exp_rv ? tgt : m_last_rpc);
        chk("res_bf", 32'(bce_bf), 32'd0);
        chk("res_ready", 32'(br_ready), 32'd0);
        if (killc != 2) begin
            if (m_br != -1) m_br++;
            if (mis) begin
                m_mis++;
                m_last_rpc = tgt;
            end
        end
        next_cycle();
        kill     = 1'b0;
        br_valid = 1'b0;
    endtask

    initial begin
        n_tot      = 0;
        n_pass     = 0;
        m_last_rpc = 32'd0;
        m_br       = 0;
        m_mis      = 0;
        rst_n      = 1'b0;
        br_valid   = 1'b0;
        br_bf      = 4'd0;
        br_pc      = 32'd0;
        br_off     = 32'd0;
        br_pred    = 1'b0;
        ops_rdy    = 1'b0;
        rs_val     = 32'd0;
        rt_val     = 32'd0;
        kill       = 1'b0;
        #12;
        chk("rst_ready", 32'(br_ready), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rv", 32'(redirect_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_pc", redirect_pc, 32'd0);
        chk("rst_a", bce_a, 32'd0);
        chk("rst_b", bce_b, 32'd0);
        chk("rst_bf", 32'(bce_bf), 32'd0);
        rst_n = 1'b1;
        next_cycle();

        run_branch(4'b0010, 32'h100, 32'h20, 1'b0, 32'h8000_0000, 32'd0, 0, -1);
        chk("dir1_pc", redirect_pc, 32'h124);
        run_branch(4'b1000, 32'h200, 32'h40, 1'b1, 32'd5, 32'd5, 0, -1);
        run_branch(4'b1010, 32'h300, 32'h10, 1'b0, 32'd1, 32'd2, 3, -1);
        run_branch(4'b0011, 32'hFFFF_FFFC, 32'd8, 1'b0, 32'd1, 32'd0, 0, -1);
        run_branch(4'b0100, 32'h400, 32'h80, 1'b1, 32'd1, 32'd2, 0, -1);
        run_branch(4'b0010, 32'h500, 32'h10, 1'b0, 32'h8000_0000, 32'd0, 0, 1);
        run_branch(4'b0010, 32'h600, 32'h10, 1'b0, 32'h8000_0000, 32'd0, 0, 2);
        run_branch(4'b1001, 32'h700, 32'h10, 1'b0, 32'd3, 32'd4, 2, 0);

        br_valid = 1'b1;
        br_bf    = 4'b0010;
        br_pc    = 32'h800;
        br_off   = 32'h4;
        br_pred  = 1'b0;
        ops_rdy  = 1'b1;
        rs_val   = 32'h8000_0000;
        kill     = 1'b1;
        #2;
        chk("kidle_ready", 32'(br_ready), 32'd1);
        next_cycle();
        br_valid = 1'b0;
        kill     = 1'b0;
        #2;
        chk("kidle_ready2", 32'(br_ready), 32'd1);
        chk("kidle_stall", 32'(stall), 32'd0);
        chk("kidle_bf", 32'(bce_bf), 32'd0);
        next_cycle();

        br_valid = 1'b1;
        br_bf    = 4'b1000;
        ops_rdy  = 1'b0;
        #2;
        next_cycle();
        br_valid = 1'b0;
        #1;
        chk("rstw_stall_pre", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstw_stall", 32'(stall), 32'd0);
        chk("rstw_ready", 32'(br_ready), 32'd1);
        chk("rstw_rv", 32'(redirect_valid), 32'd0);
        chk("rstw_flush", 32'(flush), 32'd0);
        chk("rstw_pc", redirect_pc, 32'd0);
        chk("rstw_a", bce_a, 32'd0);
        chk("rstw_b", bce_b, 32'd0);
        chk("rstw_bf", 32'(bce_bf), 32'd0);
        m_last_rpc = 32'd0;
        m_br       = 0;
        m_mis      = 0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        for (int k = 0; k < 60; k++) begin
            logic [31:0] a;
            logic [31:0] b;
            int          d;
            int          r;
            int          kc;
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            d  = $urandom_range(0, 3);
            r  = $urandom_range(0, 9);
            kc = -1;
            if (r == 0) kc = 1;
            if (r == 1) kc = 2;
            if (r == 2 && d > 0) kc = 0;
            run_branch(4'($urandom), $urandom, $urandom,
                       1'($urandom_range(0, 1)), a, b, d, kc);
        end

        #2;
        chk("end_ready", 32'(br_ready), 32'd1);
        chk("end_rv", 32'(redirect_valid), 32'd0);
`ifdef BR_STATS_EN
        chk("stat_br", br_cnt, 32'(m_br));
        chk("stat_mis", mis_cnt, 32'(m_mis));
`endif
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
